// File: rtl/sram_dp_clr.sv
// Simple dual-port, byte-writable SRAM with a self-timed clear sweep.
// A single write port is shared between user writes and the sweep; reads are pipelined (1 or 2 cycles).
module sram_dp_clr #(
    parameter int DW         = 32,
    parameter int AW         = 13,
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              busy,
    input  logic              wen,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic [DW/8-1:0]   wbe,
    input  logic              ren,
    input  logic [AW-1:0]     raddr,
    output logic [DW-1:0]     rdata,
    output logic              rvalid
);

    localparam int            DEPTH     = 2 ** AW;
    localparam int            NB        = DW / 8;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic logic [DW-1:0] byte_merge(
        input logic [DW-1:0] old_word,
        input logic [DW-1:0] new_word,
        input logic [NB-1:0] be
    );
        logic [DW-1:0] res;
        res = old_word;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_word[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_word[8*b +: 8];
            end
        end
        return res;
    endfunction

    logic [DW-1:0] mem_r [DEPTH];

    state_t        state_r;
    state_t        state_nxt_s;
    logic [AW-1:0] clr_ptr_r;
    logic [AW-1:0] clr_ptr_nxt_s;
    logic          busy_r;

    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [DW-1:0] wr_data_s;
    logic [NB-1:0] wr_be_s;

    logic          rd_acc_s;
    logic          rdw_hit_s;
    logic [DW-1:0] rd_word_s;
    logic          rd1_vld_r;
    logic [DW-1:0] rd1_data_r;

    // Clear-sweep next-state and pointer logic
    always_comb begin
        state_nxt_s   = state_r;
        clr_ptr_nxt_s = clr_ptr_r;
        case (state_r)
            ST_IDLE: begin
                if (clr_req) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_ptr_nxt_s = {AW{1'b0}};
                end else begin
                    state_nxt_s   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                clr_ptr_nxt_s = clr_ptr_r + AW'(1'b1);
                if (clr_ptr_r == LAST_ADDR) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                clr_ptr_nxt_s = {AW{1'b0}};
            end
        endcase
    end

    // State, pointer and busy registers; reset optionally kicks off a fresh sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            clr_ptr_r <= {AW{1'b0}};
            busy_r    <= (CLR_ON_RST != 0);
        end else begin
            state_r   <= state_nxt_s;
            clr_ptr_r <= clr_ptr_nxt_s;
            busy_r    <= (state_nxt_s == ST_CLEAR);
        end
    end

    assign busy = busy_r;

    // Write-port mux: the sweep owns the port while clearing, user writes otherwise
    always_comb begin
        if (state_r == ST_CLEAR) begin
            wr_en_s   = 1'b1;
            wr_addr_s = clr_ptr_r;
            wr_data_s = {DW{1'b0}};
            wr_be_s   = {NB{1'b1}};
        end else begin
            wr_en_s   = wen;
            wr_addr_s = waddr;
            wr_data_s = wdata;
            wr_be_s   = wbe;
        end
    end

    // Byte-enabled array write; the array itself is never reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_en_s && wr_be_s[b]) begin
                mem_r[wr_addr_s][8*b +: 8] <= wr_data_s[8*b +: 8];
            end
        end
    end

    // Read acceptance and same-address bypass selection
    always_comb begin
        rd_acc_s  = ren && (state_r == ST_IDLE);
        rdw_hit_s = (RDW_MODE == 1) && wen && (state_r == ST_IDLE) && (waddr == raddr);
        if (rdw_hit_s) begin
            rd_word_s = byte_merge(mem_r[raddr], wdata, wbe);
        end else begin
            rd_word_s = mem_r[raddr];
        end
    end

    // First read stage; data only moves when a read was accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_vld_r  <= 1'b0;
            rd1_data_r <= {DW{1'b0}};
        end else begin
            rd1_vld_r <= rd_acc_s;
            if (rd_acc_s) begin
                rd1_data_r <= rd_word_s;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          rvalid_r;
            logic [DW-1:0] rdata_r;

            // Second read stage; rdata holds between completions
            always_ff @(posedge clk) begin
                if (rst) begin
                    rvalid_r <= 1'b0;
                    rdata_r  <= {DW{1'b0}};
                end else begin
                    rvalid_r <= rd1_vld_r;
                    if (rd1_vld_r) begin
                        rdata_r <= rd1_data_r;
                    end
                end
            end

            assign rvalid = rvalid_r;
            assign rdata  = rdata_r;
        end else begin : g_lat1
            assign rvalid = rd1_vld_r;
            assign rdata  = rd1_data_r;
        end
    endgenerate

endmodule

// File: tb/tb_sram_dp_clr.sv
// Bench for sram_dp_clr: two configurations share one stimulus stream and are compared
// every cycle against an array/queue reference model.
module tb_sram_dp_clr;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_req;
    logic          wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [3:0]    wbe;
    logic          ren;
    logic [AW-1:0] raddr;

    logic          busy_a;
    logic          rvalid_a;
    logic [DW-1:0] rdata_a;
    logic          busy_b;
    logic          rvalid_b;
    logic [DW-1:0] rdata_b;

    always #5 clk = ~clk;

    sram_dp_clr #(.DW(DW), .AW(AW), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(1)) u_a (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_a),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a)
    );

    sram_dp_clr #(.DW(DW), .AW(AW), .RD_LAT(2), .RDW_MODE(1), .CLR_ON_RST(0)) u_b (
        .clk(clk), .rst(rst), .clr_req(clr_req), .busy(busy_b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wbe(wbe),
        .ren(ren), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b)
    );

    typedef struct {
        int          inst;
        int          due;
        logic [31:0] data;
    } rd_item_t;

    rd_item_t    pend[$];
    logic [31:0] mdl_mem [2][DEPTH];
    int          clr_left [2];
    logic        exp_busy [2];
    logic        exp_rvalid [2];
    logic [31:0] exp_rdata [2];
    int          lat [2] = '{1, 2};
    int          rdw [2] = '{0, 1};
    int          cor [2] = '{1, 0};
    int          cyc;
    int          n_chk;
    int          n_fail;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (n & mask) | (o & ~mask);
    endfunction

    // Retire the read of instance k due at the current edge, if any.
    task automatic complete(input int k);
        exp_rvalid[k] = 1'b0;
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].inst == k && pend[i].due == cyc) begin
                exp_rvalid[k] = 1'b1;
                exp_rdata[k]  = pend[i].data;
                pend.delete(i);
                break;
            end
        end
    endtask

    // Effect of the coming clock edge on each instance, from the current inputs.
    task automatic model_edge();
        rd_item_t it;
        for (int k = 0; k < 2; k++) begin
            if (clr_left[k] > 0) begin
                mdl_mem[k][DEPTH - clr_left[k]] = 32'h0;
            end
            if (rst) begin
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i].inst == k) begin
                        pend.delete(i);
                        i--;
                    end
                end
                clr_left[k]   = (cor[k] != 0) ? DEPTH : 0;
                exp_rvalid[k] = 1'b0;
                exp_rdata[k]  = 32'h0;
            end else if (clr_left[k] > 0) begin
                clr_left[k]--;
                complete(k);
            end else begin
                if (ren) begin
                    it.inst = k;
                    it.due  = cyc + lat[k] - 1;
                    if (rdw[k] == 1 && wen && waddr == raddr) begin
                        it.data = merge(mdl_mem[k][raddr], wdata, wbe);
                    end else begin
                        it.data = mdl_mem[k][raddr];
                    end
                    pend.push_back(it);
                end
                if (wen) begin
                    mdl_mem[k][waddr] = merge(mdl_mem[k][waddr], wdata, wbe);
                end
                if (clr_req) begin
                    clr_left[k] = DEPTH;
                end
                complete(k);
            end
            exp_busy[k] = (clr_left[k] > 0);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("A.busy",   32'(busy_a),   32'(exp_busy[0]));
        chk("A.rvalid", 32'(rvalid_a), 32'(exp_rvalid[0]));
        chk("A.rdata",  rdata_a,       exp_rdata[0]);
        chk("B.busy",   32'(busy_b),   32'(exp_busy[1]));
        chk("B.rvalid", 32'(rvalid_b), 32'(exp_rvalid[1]));
        chk("B.rdata",  rdata_b,       exp_rdata[1]);
        cyc++;
    endtask

    task automatic idle_in();
        rst     = 1'b0;
        clr_req = 1'b0;
        wen     = 1'b0;
        ren     = 1'b0;
        waddr   = 4'h0;
        raddr   = 4'h0;
        wdata   = 32'h0;
        wbe     = 4'h0;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (clr_left[0] == 0 && clr_left[1] == 0) begin
                break;
            end
            tick();
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        idle_in();
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        wbe   = be;
        tick();
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) begin
            idle_in();
            ren   = 1'b1;
            raddr = 4'(a);
            tick();
        end
        idle_in();
        repeat (3) tick();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        for (int k = 0; k < 2; k++) begin
            clr_left[k]   = 0;
            exp_rvalid[k] = 1'b0;
            exp_rdata[k]  = 32'h0;
            exp_busy[k]   = 1'b0;
            for (int a = 0; a < DEPTH; a++) begin
                mdl_mem[k][a] = 32'h0;
            end
        end

        // Reset: A sweeps on its own, B is cleared by an explicit request.
        idle_in();
        rst = 1'b1;
        tick();
        idle_in();
        clr_req = 1'b1;
        tick();
        idle_in();
        wait_idle(40);
        read_all();

        // Byte-enable merge on address 5.
        do_write(4'd5, 32'h11223344, 4'b1111);
        do_write(4'd5, 32'hAABBCCDD, 4'b0101);
        idle_in();
        ren   = 1'b1;
        raddr = 4'd5;
        tick();
        idle_in();
        repeat (3) tick();

        // Same-address read during write on a zeroed word.
        idle_in();
        wen   = 1'b1;
        waddr = 4'd3;
        wdata = 32'hDEADBEEF;
        wbe   = 4'b1111;
        ren   = 1'b1;
        raddr = 4'd3;
        tick();
        idle_in();
        repeat (3) tick();

        // Back-to-back reads of 0..3.
        for (int a = 0; a < 4; a++) begin
            do_write(4'(a), 32'(32'hA0 + a), 4'b1111);
        end
        for (int a = 0; a < 4; a++) begin
            idle_in();
            ren   = 1'b1;
            raddr = 4'(a);
            tick();
        end
        idle_in();
        repeat (3) tick();

        // Clear request together with a read; traffic during busy is ignored.
        do_write(4'd7, 32'h12345678, 4'b1111);
        idle_in();
        clr_req = 1'b1;
        ren     = 1'b1;
        raddr   = 4'd7;
        tick();
        for (int i = 0; i < 6; i++) begin
            idle_in();
            wen   = 1'b1;
            ren   = 1'b1;
            waddr = 4'($urandom_range(0, 15));
            raddr = 4'($urandom_range(0, 15));
            wdata = $urandom;
            wbe   = 4'b1111;
            tick();
        end
        idle_in();
        wait_idle(40);
        read_all();

        // Reset in the middle of a sweep, at clear pointer 9.
        for (int a = 0; a < DEPTH; a++) begin
            do_write(4'(a), $urandom, 4'b1111);
        end
        idle_in();
        clr_req = 1'b1;
        tick();
        idle_in();
        for (int i = 0; i < 20; i++) begin
            if (DEPTH - clr_left[0] == 9) begin
                break;
            end
            tick();
        end
        rst = 1'b1;
        tick();
        idle_in();
        wait_idle(40);
        read_all();

        // Randomised traffic with occasional clears and resets.
        for (int i = 0; i < 500; i++) begin
            idle_in();
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
            end else begin
                clr_req = ($urandom_range(0, 59) == 0);
                wen     = $urandom_range(0, 1) == 1;
                ren     = $urandom_range(0, 1) == 1;
                waddr   = 4'($urandom_range(0, 15));
                raddr   = ($urandom_range(0, 3) == 0) ? waddr : 4'($urandom_range(0, 15));
                wdata   = $urandom;
                wbe     = 4'($urandom_range(0, 15));
            end
            tick();
        end
        idle_in();
        wait_idle(40);
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/sram_dp_clr.md
SRAM_DP_CLR -- requirements
Module: sram_dp_clr

Interface
- Parameters (name, default, meaning):
  - REQ-001: The block SHALL have parameter DW, default 32: data width in bits; legal only as a multiple of 8.
  - REQ-002: The block SHALL have parameter AW, default 13: address width; DEPTH = 2**AW words, derived and not overridable.
  - REQ-003: The block SHALL have parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
  - REQ-004: The block SHALL have parameter RDW_MODE, default 0: same-address read-during-write behaviour; 0 = read-old, 1 = write-through.
  - REQ-005: The block SHALL have parameter CLR_ON_RST, default 1: 1 = run a clear sweep automatically after reset.
- Ports (name, direction, width, meaning):
  - REQ-006: The block SHALL have port clk, input, 1: the single clock; all logic is on its rising edge.
  - REQ-007: The block SHALL have port rst, input, 1: reset, synchronous and active-high.
  - REQ-008: The block SHALL have port clr_req, input, 1: request to zero the whole array.
  - REQ-009: The block SHALL have port busy, output, 1: high while a clear sweep is in progress.
  - REQ-010: The block SHALL have port wen, input, 1: write enable.
  - REQ-011: The block SHALL have port waddr, input, AW: write address.
  - REQ-012: The block SHALL have port wdata, input, DW: write data.
  - REQ-013: The block SHALL have port wbe, input, DW/8: byte enables; bit i selects wdata[8i+7:8i].
  - REQ-014: The block SHALL have port ren, input, 1: read enable.
  - REQ-015: The block SHALL have port raddr, input, AW: read address.
  - REQ-016: The block SHALL have port rdata, output, DW: read data.
  - REQ-017: The block SHALL have port rvalid, output, 1: pulses high for one cycle when rdata carries a new read result.

Function
- REQ-018: The block SHALL hold an FSM with two states, IDLE and CLEAR, and an AW-bit clear pointer clr_ptr.
- REQ-019: In IDLE, clr_req=1 SHALL move the FSM to CLEAR on the next edge, with clr_ptr=0.
- REQ-020: In CLEAR, each cycle the block SHALL write all-zero to mem[clr_ptr] and increment clr_ptr.
- REQ-021: In CLEAR, the cycle that writes mem[DEPTH-1] SHALL return the FSM to IDLE; a sweep therefore lasts exactly DEPTH cycles.
- REQ-022: busy SHALL equal (state==CLEAR), registered, with no combinational path from clr_req.
- REQ-023: clr_req asserted while in CLEAR SHALL be ignored; the sweep is not restarted and the request is not queued.
- REQ-024: While busy=1, wen and ren SHALL be ignored: no array update and no rvalid generated.
- REQ-025: In IDLE with wen=1, for each i with wbe[i]=1, mem[waddr] byte i SHALL take wdata byte i on the edge; bytes with wbe[i]=0 are unchanged.
- REQ-026: wen=1 with wbe=0 SHALL be a no-op.
- REQ-027: In IDLE with ren=1 at edge N, rdata SHALL present mem[raddr] and rvalid SHALL be 1 in the cycle after edge N+RD_LAT-1 (RD_LAT=1: valid after edge N; RD_LAT=2: after edge N+1).
- REQ-028: Back-to-back reads SHALL be accepted every cycle at full throughput.
- REQ-029: rdata SHALL hold its last value when no read completes; it is not cleared when rvalid falls.
- REQ-030: For a read and a write to the same address in the same cycle with RDW_MODE=0, rdata SHALL return the pre-write word.
- REQ-031: For a read and a write to the same address in the same cycle with RDW_MODE=1, rdata SHALL return the merged word: wdata bytes where wbe=1, old bytes elsewhere.
- REQ-032: For a write and a read at different addresses in the same cycle, the two operations SHALL be independent.
- REQ-033: When clr_req and wen/ren arrive in the same IDLE cycle, the write and read SHALL both be performed, and the clear SHALL start on the next cycle.
- REQ-034: A read accepted before CLEAR is entered SHALL complete normally, with its rvalid, even if that rvalid lands during busy.
- REQ-035: A read issued after a completed sweep SHALL return 0 for every address not written since the sweep.

Reset
- REQ-036: When rst=1 at an edge, the block SHALL set rvalid=0 and rdata=0, and flush the read pipeline (no in-flight rvalid survives).
- REQ-037: When rst=1 at an edge with CLR_ON_RST=1, the block SHALL set state=CLEAR, clr_ptr=0, busy=1 in the cycle after reset.
- REQ-038: When rst=1 at an edge with CLR_ON_RST=0, the block SHALL set state=IDLE and busy=0.
- REQ-039: Reset during CLEAR SHALL restart the sweep from address 0 when CLR_ON_RST=1, and abort it when CLR_ON_RST=0.
- REQ-040: Array contents SHALL never be modified by rst itself.

Verification (AW=4, DW=32)
- REQ-041: Bench SHALL apply rst 1 cycle, with CLR_ON_RST=1 -> required response: busy high for exactly 16 cycles, then 0; reads of addresses 0..15 return 0x00000000.
- REQ-042: Bench SHALL write 0x11223344 to addr 5 with wbe=4'b1111, then write 0xAABBCCDD with wbe=4'b0101, then read addr 5 -> required response: rdata=0x11BB33DD; rvalid after 1 cycle (RD_LAT=1) or 2 cycles (RD_LAT=2).
- REQ-043: Bench SHALL hold addr 3=0x0, then in the same cycle write 0xDEADBEEF (wbe=4'b1111) and read addr 3 -> required response: rdata=0x00000000 with RDW_MODE=0; rdata=0xDEADBEEF with RDW_MODE=1.
- REQ-044: Bench SHALL pulse clr_req together with a read of addr 7 (=0x12345678), then issue wen and ren during busy -> required response: rvalid with 0x12345678; no further rvalid; addr 7 reads 0 after the sweep.
- REQ-045: Bench SHALL assert rst at clr_ptr=9 mid-sweep -> required response: busy stays high, sweep restarts from address 0 and takes 16 more cycles (CLR_ON_RST=1); busy drops the cycle after reset (CLR_ON_RST=0).
- REQ-046: Bench SHALL issue reads of addresses 0..3 on consecutive cycles (contents 0xA0..0xA3) with RD_LAT=2 -> required response: rvalid high 4 consecutive cycles starting 2 cycles later, with rdata 0xA0, 0xA1, 0xA2, 0xA3 in order.
